// File: rtl/ram_req_ctrl.sv
// Request sequencer in front of the RAM array: one request at a time, fixed-length strobe, one-cycle response.
// Optional parity (macro RAM_REQ_CTRL_PARITY_EN): mem_wpar on writes, rsp_perr on reads.
module ram_req_ctrl #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 8,
  parameter int WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic              rsp_we,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
`ifdef RAM_REQ_CTRL_PARITY_EN
  ,
  output logic              mem_wpar,
  input  logic              mem_rpar,
  output logic              rsp_perr
`endif
);

  // state  | meaning
  // IDLE   | ready for a request
  // ACCESS | strobe held on the array, counter runs down to 0
  // RESP   | one-cycle response pulse
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYC);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] cnt;
  logic       op;
  logic       accept;
  logic       done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          accept    = 1'b1;
          state_nxt = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (cnt == 4'd0) begin
          done      = 1'b1;
          state_nxt = S_RESP;
        end
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Strobes are flops so they toggle only on ACCESS entry and exit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= 4'd0;
      op        <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      rsp_we    <= 1'b0;
      rsp_rdata <= '0;
    end else if (accept) begin
      mem_addr  <= req_addr;
      mem_wdata <= req_wdata;
      op        <= req_we;
      cnt       <= WAIT_LD;
      mem_we    <= req_we;
      mem_re    <= !req_we;
    end else if (state == S_ACCESS) begin
      if (done) begin
        mem_we    <= 1'b0;
        mem_re    <= 1'b0;
        rsp_we    <= op;
        rsp_rdata <= op ? '0 : mem_rdata;
      end else begin
        cnt <= cnt - 4'd1;
      end
    end
  end

`ifdef RAM_REQ_CTRL_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_wpar <= 1'b0;
      rsp_perr <= 1'b0;
    end else if (accept) begin
      mem_wpar <= ^req_wdata;
    end else if (done) begin
      rsp_perr <= !op && ((^mem_rdata) != mem_rpar);
    end
  end
`endif

  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign rsp_valid = (state == S_RESP);

endmodule
